// File: rtl/hough_pkg.sv
// Shared types for the Hough peak finder: field-width defaults, peak entry and FSM states.
package hough_pkg;

    localparam int RHO_BITS_DEF   = 9;
    localparam int THETA_BITS_DEF = 8;
    localparam int COUNT_BITS_DEF = 12;

    // Entry fields are sized at the defaults; narrower instances zero-extend into them.
    typedef struct packed {
        logic [RHO_BITS_DEF-1:0]   rho;
        logic [THETA_BITS_DEF-1:0] theta;
        logic [COUNT_BITS_DEF-1:0] votes;
        logic                      valid;
    } peak_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/hough_peak_finder_insert.sv
// Combinational compare/shift network for the sorted peak table.
// Optional neighbour suppression is enabled by defining HOUGH_PEAK_NMS_EN.
module peak_insert
    import hough_pkg::*;
#(
    parameter int NUM_PEAKS  = 4,
    parameter int MIN_VOTES  = 40,
    parameter int THETA_BITS = THETA_BITS_DEF,
    parameter int RHO_WIN    = 8,
    parameter int THETA_WIN  = 4
) (
    input  peak_t [NUM_PEAKS-1:0] table_in,
    input  logic                  cand_en,
    input  peak_t                 cand,
    output peak_t [NUM_PEAKS-1:0] table_out
);

    logic [NUM_PEAKS-1:0] beats;
    logic                 suppress;
    logic                 accept;

    always_comb begin
        for (int unsigned i = 0; i < NUM_PEAKS; i++) begin
            beats[i] = !table_in[i].valid || (cand.votes > table_in[i].votes);
        end
    end

`ifdef HOUGH_PEAK_NMS_EN
    always_comb begin
        logic [RHO_BITS_DEF-1:0] rd;
        logic [THETA_BITS-1:0]   td;
        logic [THETA_BITS-1:0]   tdn;
        suppress = 1'b0;
        for (int unsigned i = 0; i < NUM_PEAKS; i++) begin
            rd  = (table_in[i].rho >= cand.rho) ? table_in[i].rho - cand.rho
                                                : cand.rho - table_in[i].rho;
            // Truncated subtraction gives the modular distance in each direction.
            td  = table_in[i].theta[THETA_BITS-1:0] - cand.theta[THETA_BITS-1:0];
            tdn = cand.theta[THETA_BITS-1:0] - table_in[i].theta[THETA_BITS-1:0];
            if (table_in[i].valid && (table_in[i].votes >= cand.votes) &&
                (rd <= RHO_BITS_DEF'(RHO_WIN)) &&
                ((td <= THETA_BITS'(THETA_WIN)) || (tdn <= THETA_BITS'(THETA_WIN)))) begin
                suppress = 1'b1;
            end
        end
    end
`else
    localparam int unused_win = RHO_WIN + THETA_WIN + THETA_BITS;
    assign suppress = 1'b0;
`endif

    assign accept = cand_en && !suppress &&
                    (cand.votes >= COUNT_BITS_DEF'(MIN_VOTES));

    // Valid entries are contiguous and descending, so beats is monotone and the
    // first set bit marks the insertion slot; everything after it shifts down.
    always_comb begin
        table_out = table_in;
        if (accept) begin
            if (beats[0]) table_out[0] = cand;
            for (int unsigned i = 1; i < NUM_PEAKS; i++) begin
                if (beats[i-1])   table_out[i] = table_in[i-1];
                else if (beats[i]) table_out[i] = cand;
            end
        end
    end

endmodule

// File: rtl/hough_peak_finder.sv
// Scans the Hough accumulator and keeps the NUM_PEAKS strongest cells, sorted by votes.
// Define HOUGH_PEAK_NMS_EN to suppress candidates near a stronger retained peak.
module hough_peak_finder
    import hough_pkg::*;
#(
    parameter int RHO_BITS    = RHO_BITS_DEF,
    parameter int THETA_BITS  = THETA_BITS_DEF,
    parameter int COUNT_BITS  = COUNT_BITS_DEF,
    parameter int NUM_PEAKS   = 4,
    parameter int MEM_LATENCY = 2,
    parameter int MIN_VOTES   = 40,
    parameter int RHO_WIN     = 8,
    parameter int THETA_WIN   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    output logic                             done,
    output logic                             busy,
    output logic [RHO_BITS+THETA_BITS-1:0]   mem_addr,
    input  logic [COUNT_BITS-1:0]            mem_data,
    output logic [NUM_PEAKS*RHO_BITS-1:0]    peak_rho,
    output logic [NUM_PEAKS*THETA_BITS-1:0]  peak_theta,
    output logic [NUM_PEAKS*COUNT_BITS-1:0]  peak_votes,
    output logic [NUM_PEAKS-1:0]             peak_valid
);

    localparam int A  = RHO_BITS + THETA_BITS;
    localparam int DW = $clog2(MEM_LATENCY + 1) + 1;

    state_t                state, state_n;
    logic [A-1:0]          addr;
    logic [DW-1:0]         drain_cnt;
    logic [A-1:0]          tag_pipe [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] vld_pipe;
    peak_t [NUM_PEAKS-1:0] table_q, table_n;
    peak_t                 cand;
    logic                  unused_tbl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_SCAN;
            ST_SCAN:  if (addr == '1) state_n = ST_DRAIN;
            ST_DRAIN: if (drain_cnt == DW'(MEM_LATENCY)) state_n = ST_DONE;
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr      <= '0;
            drain_cnt <= '0;
        end else begin
            addr      <= (state == ST_SCAN)  ? addr + 1'b1      : '0;
            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;
        end
    end

    // Address tags follow each read so the returning data knows its cell.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            for (int unsigned i = 0; i < MEM_LATENCY; i++) tag_pipe[i] <= '0;
        end else begin
            tag_pipe[0] <= addr;
            vld_pipe[0] <= (state == ST_SCAN);
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    always_comb begin
        cand       = '0;
        cand.rho   = RHO_BITS_DEF'(tag_pipe[MEM_LATENCY-1][RHO_BITS-1:0]);
        cand.theta = THETA_BITS_DEF'(tag_pipe[MEM_LATENCY-1][A-1:RHO_BITS]);
        cand.votes = COUNT_BITS_DEF'(mem_data);
        cand.valid = 1'b1;
    end

    peak_insert #(
        .NUM_PEAKS (NUM_PEAKS),
        .MIN_VOTES (MIN_VOTES),
        .THETA_BITS(THETA_BITS),
        .RHO_WIN   (RHO_WIN),
        .THETA_WIN (THETA_WIN)
    ) u_insert (
        .table_in (table_q),
        .cand_en  (vld_pipe[MEM_LATENCY-1]),
        .cand     (cand),
        .table_out(table_n)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                            table_q <= '0;
        else if ((state == ST_IDLE) && start) table_q <= '0;
        else                                  table_q <= table_n;
    end

    assign mem_addr = (state == ST_SCAN) ? addr : '0;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        for (int unsigned i = 0; i < NUM_PEAKS; i++) begin
            peak_rho[i*RHO_BITS +: RHO_BITS]       = table_q[i].rho[RHO_BITS-1:0];
            peak_theta[i*THETA_BITS +: THETA_BITS] = table_q[i].theta[THETA_BITS-1:0];
            peak_votes[i*COUNT_BITS +: COUNT_BITS] = table_q[i].votes[COUNT_BITS-1:0];
            peak_valid[i]                          = table_q[i].valid;
        end
    end

    assign unused_tbl = ^table_q;

endmodule

// File: tb/tb_hough_peak_finder.sv
// Directed bench for hough_peak_finder on a 32-cell accumulator with a sort-based reference model.
module tb_hough_peak_finder;

    localparam int RB = 3, TB = 2, CB = 12, NP = 4, ML = 2, MV = 5, RW = 1, TW = 1;
    localparam int NC = 32;
    localparam int DONE_PH = NC + ML + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic done, busy;
    logic [RB+TB-1:0] mem_addr;
    logic [CB-1:0]    mem_data;
    logic [NP*RB-1:0] peak_rho;
    logic [NP*TB-1:0] peak_theta;
    logic [NP*CB-1:0] peak_votes;
    logic [NP-1:0]    peak_valid;

    logic [CB-1:0]    mem [NC];
    logic [RB+TB-1:0] a1 = '0, a2 = '0;

    int checks = 0, failures = 0;

    hough_peak_finder #(
        .RHO_BITS(RB), .THETA_BITS(TB), .COUNT_BITS(CB), .NUM_PEAKS(NP),
        .MEM_LATENCY(ML), .MIN_VOTES(MV), .RHO_WIN(RW), .THETA_WIN(TW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .done(done), .busy(busy),
        .mem_addr(mem_addr), .mem_data(mem_data), .peak_rho(peak_rho),
        .peak_theta(peak_theta), .peak_votes(peak_votes), .peak_valid(peak_valid)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM model
    always @(posedge clk) begin
        a1 <= mem_addr;
        a2 <= a1;
    end
    assign mem_data = mem[a2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: cell addresses and votes of the expected table
    int mdl_a [NP], mdl_v [NP];
    bit mdl_ok [NP];
    int held_a [NP], held_v [NP];
    bit held_ok [NP];
    int t_a [NP], t_v [NP];
    bit t_ok [NP];
    bit elig [NC];

    // Strongest eligible cells, lower address first on ties
    task automatic top4();
        bit used [NC];
        for (int a = 0; a < NC; a++) used[a] = 0;
        for (int k = 0; k < NP; k++) begin
            int best = -1;
            for (int a = 0; a < NC; a++)
                if (elig[a] && !used[a] && (best < 0 || int'(mem[a]) > int'(mem[best]))) best = a;
            if (best >= 0) begin
                used[best] = 1; t_a[k] = best; t_v[k] = int'(mem[best]); t_ok[k] = 1;
            end else begin
                t_a[k] = 0; t_v[k] = 0; t_ok[k] = 0;
            end
        end
    endtask

    task automatic compute_model();
        for (int a = 0; a < NC; a++) elig[a] = 0;
        for (int a = 0; a < NC; a++) begin
            if (int'(mem[a]) >= MV) begin
                bit sup = 0;
`ifdef HOUGH_PEAK_NMS_EN
                top4();
                for (int j = 0; j < NP; j++) begin
                    int dr, dt;
                    dr = (a % 8) - (t_a[j] % 8);
                    if (dr < 0) dr = -dr;
                    dt = ((a / 8) - (t_a[j] / 8) + 4) % 4;
                    if (dt > 2) dt = 4 - dt;
                    if (t_ok[j] && t_v[j] >= int'(mem[a]) && dr <= RW && dt <= TW) sup = 1;
                end
`endif
                if (!sup) elig[a] = 1;
            end
        end
        top4();
        for (int k = 0; k < NP; k++) begin
            mdl_a[k] = t_a[k]; mdl_v[k] = t_v[k]; mdl_ok[k] = t_ok[k];
        end
    endtask

    // Expected phase: cycles since start was accepted
    bit exp_run = 0;
    int ph = 0;
    bit held_src = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_run <= 0; ph <= 0; held_src <= 0;
        end else if (!exp_run) begin
            if (start) begin
                exp_run <= 1; ph <= 1; held_src <= 0;
            end
        end else if (ph == DONE_PH) begin
            exp_run <= 0; held_src <= 1;
            held_a <= mdl_a; held_v <= mdl_v; held_ok <= mdl_ok;
        end else begin
            ph <= ph + 1;
        end
    end

    task automatic cmp_table(input string tag, input bit use_held);
        logic [NP*RB-1:0] er;
        logic [NP*TB-1:0] et;
        logic [NP*CB-1:0] ev;
        logic [NP-1:0]    eo;
        er = '0; et = '0; ev = '0; eo = '0;
        for (int i = 0; i < NP; i++) begin
            int a, v;
            bit ok;
            a  = use_held ? held_a[i]  : mdl_a[i];
            v  = use_held ? held_v[i]  : mdl_v[i];
            ok = use_held ? held_ok[i] : mdl_ok[i];
            if (use_held && !held_src) begin a = 0; v = 0; ok = 0; end
            er[i*RB +: RB] = RB'(a % 8);
            et[i*TB +: TB] = TB'(a / 8);
            ev[i*CB +: CB] = CB'(v);
            eo[i] = ok;
        end
        check({tag, "_valid"}, peak_valid, eo);
        check({tag, "_rho"},   peak_rho,   er);
        check({tag, "_theta"}, peak_theta, et);
        check({tag, "_votes"}, peak_votes, ev);
    endtask

    always @(negedge clk) begin
        check("busy", busy, exp_run);
        check("done", done, exp_run && ph == DONE_PH);
        check("mem_addr", mem_addr, (exp_run && ph <= NC) ? ph - 1 : 0);
        if (!exp_run)            cmp_table("idle_tbl", 1);
        else if (ph == DONE_PH)  cmp_table("done_tbl", 0);
    end

    task automatic clear_mem();
        for (int a = 0; a < NC; a++) mem[a] = '0;
    endtask

    // Runs one scan; extra_ph > 0 pulses start again during that cycle
    task automatic run_scan(input int extra_ph);
        int cyc = 0;
        bit seen = 0;
        compute_model();
        @(negedge clk); #1 start = 1'b1;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            #1 start = (cyc == extra_ph);
            if (done) seen = 1;
        end
        check("done_cycle", cyc, DONE_PH);
        @(negedge clk); #1 start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcount;
        clear_mem();
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check("rst_busy", busy, 0);
        check("rst_valid", peak_valid, 0);

        // All-zero memory; start during the done cycle must be ignored
        run_scan(DONE_PH);
        check("zero_valid", peak_valid, 4'b0000);

        // Five cells, one below the fourth-strongest; start mid-scan ignored
        clear_mem();
        mem[3] = 9; mem[17] = 20; mem[30] = 12; mem[8] = 7; mem[12] = 15;
        run_scan(15);
        check("pin_mdl0", mdl_a[0], 17);
        check("pin_mdl1", mdl_a[1], 12);
        check("pin_mdl2", mdl_a[2], 30);
        check("pin_mdl3", mdl_a[3], 3);
        check("five_valid", peak_valid, 4'b1111);
        check("five_rho",   peak_rho,   {3'd3, 3'd6, 3'd4, 3'd1});
        check("five_theta", peak_theta, {2'd0, 2'd3, 2'd1, 2'd2});
        check("five_votes", peak_votes, {12'd9, 12'd12, 12'd15, 12'd20});

        // Tie: lower address ranks first
        clear_mem();
        mem[5] = 10; mem[21] = 10;
        run_scan(0);
        check("tie_valid", peak_valid, 4'b0011);
        check("tie_theta", peak_theta, {2'd0, 2'd0, 2'd2, 2'd0});
        check("tie_rho",   peak_rho,   {3'd0, 3'd0, 3'd5, 3'd5});

        // Below threshold
        clear_mem();
        mem[9] = 4;
        run_scan(0);
        check("minv_valid", peak_valid, 4'b0000);

        // Abort with reset at cycle 10, then a full rerun
        clear_mem();
        mem[3] = 9; mem[17] = 20; mem[30] = 12; mem[8] = 7; mem[12] = 15;
        compute_model();
        @(negedge clk); #1 start = 1'b1;
        @(negedge clk); #1 start = 1'b0;
        repeat (9) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_valid", peak_valid, 0);
        check("abort_votes", peak_votes, 0);
        @(negedge clk); #1 reset = 1'b0;
        dcount = 0;
        repeat (45) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        run_scan(0);
        check("rerun_votes", peak_votes, {12'd9, 12'd12, 12'd15, 12'd20});

        // Neighbourhood case with theta wrap
        clear_mem();
        mem[2] = 20; mem[27] = 18; mem[6] = 18;
        run_scan(0);
`ifdef HOUGH_PEAK_NMS_EN
        check("nms_valid", peak_valid, 4'b0011);
        check("nms_rho",   peak_rho,   {3'd0, 3'd0, 3'd6, 3'd2});
`else
        check("nms_off_valid", peak_valid, 4'b0111);
        check("nms_off_rho",   peak_rho,   {3'd0, 3'd3, 3'd6, 3'd2});
        check("nms_off_theta", peak_theta, {2'd0, 2'd3, 2'd0, 2'd0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
